// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: counting modes and control FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // Encoding 3 is reserved and behaves as WRAP.
  function automatic mode_e decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? WRAP : mode_e'(m);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: counts en cycles 0..PRESCALE-1 and issues tick on the en cycle at PRESCALE-1.
// tick is combinational from en; clr returns the phase to zero.
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en && (phase == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/counter_updown.sv
// Up/down counter with WRAP/SAT/ONESHOT bound handling, load and terminal-count pulse.
// Optional enable prescaler compiled in with macro COUNTER_PRESCALER_EN.
module counter_updown
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] SPAN    = (WIDTH+1)'(MAX_VAL + 1);

  logic             tick;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  mode_e            cur_mode;

  logic [WIDTH:0]   c_ext, s_ext, lv_ext, sum;
  logic             ovf, unf, bound_hit;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALER_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (ld),
    .tick (tick)
  );
`else
  // Without the divider every enabled cycle is a tick; an illegal PRESCALE stops counting.
  assign tick = en && (PRESCALE >= 1);
`endif

  // All bound tests run one bit wider so count+step cannot alias.
  always_comb begin
    c_ext     = {1'b0, count};
    s_ext     = {1'b0, step};
    lv_ext    = {1'b0, load_val};
    sum       = c_ext + s_ext;
    ovf       = (sum > MAX_EXT);
    unf       = (s_ext > c_ext);
    bound_hit = dir ? unf : ovf;
    cur_mode  = decode_mode(mode);
    load_clamped = (lv_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
  end

  always_comb begin
    state_d = state_q;
    count_d = count;
    tc_d    = 1'b0;

    if (ld) begin
      count_d = load_clamped;
      state_d = RUN;
    end else if (tick && (state_q == RUN) && (step != '0)) begin
      if (!dir) begin
        if (!ovf) begin
          count_d = WIDTH'(sum);
        end else if (cur_mode == WRAP) begin
          count_d = WIDTH'(sum - SPAN);
          tc_d    = 1'b1;
        end else begin
          count_d = MAX_EXT[WIDTH-1:0];
          tc_d    = (c_ext != MAX_EXT);
        end
      end else begin
        if (!unf) begin
          count_d = WIDTH'(c_ext - s_ext);
        end else if (cur_mode == WRAP) begin
          count_d = WIDTH'(c_ext + SPAN - s_ext);
          tc_d    = 1'b1;
        end else begin
          count_d = '0;
          tc_d    = (count != '0);
        end
      end

      if (bound_hit && (cur_mode == ONESHOT)) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      count   <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      tc      <= tc_d;
    end
  end

  assign done = (state_q == HALT);

endmodule

// File: tb/tb_counter_updown.sv
// Self-checking bench: three counter instances with different bounds driven by shared
// controls, compared every cycle against an arithmetic reference model.
module tb_counter_updown;

  localparam int P = 4;
`ifdef COUNTER_PRESCALER_EN
  localparam int PSC = P;
`else
  localparam int PSC = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, en, ld, dir;
  logic [1:0] mode;
  logic [7:0] lv_a, step_a, count_a;
  logic [7:0] lv_b, step_b, count_b;
  logic [8:0] lv_c, step_c, count_c;
  logic       tc_a, tc_b, tc_c, done_a, done_b, done_c;

  int checks   = 0;
  int failures = 0;

  int mx[3] = '{9, 255, 200};
  int m_cnt[3];
  int m_tc[3];
  int m_halt[3];
  int m_pre;

  counter_updown #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(P)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .load_val(lv_a), .dir(dir), .mode(mode),
    .step(step_a), .count(count_a), .tc(tc_a), .done(done_a));

  counter_updown #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(P)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .load_val(lv_b), .dir(dir), .mode(mode),
    .step(step_b), .count(count_b), .tc(tc_b), .done(done_b));

  counter_updown #(.WIDTH(9), .MAX_VAL(200), .PRESCALE(P)) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .load_val(lv_c), .dir(dir), .mode(mode),
    .step(step_c), .count(count_c), .tc(tc_c), .done(done_c));

  always #5 clk = ~clk;

  function automatic int cur_step(input int i);
    case (i)
      0:       return int'(step_a);
      1:       return int'(step_b);
      default: return int'(step_c);
    endcase
  endfunction

  function automatic int cur_lv(input int i);
    case (i)
      0:       return int'(lv_a);
      1:       return int'(lv_b);
      default: return int'(lv_c);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count_a", 32'(count_a), m_cnt[0]);
    chk("tc_a",    32'(tc_a),    m_tc[0]);
    chk("done_a",  32'(done_a),  m_halt[0]);
    chk("count_b", 32'(count_b), m_cnt[1]);
    chk("tc_b",    32'(tc_b),    m_tc[1]);
    chk("done_b",  32'(done_b),  m_halt[1]);
    chk("count_c", 32'(count_c), m_cnt[2]);
    chk("tc_c",    32'(tc_c),    m_tc[2]);
    chk("done_c",  32'(done_c),  m_halt[2]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_tc[i]   = 0;
      m_halt[i] = 0;
    end
    m_pre = 0;
  endtask

  // Reference behaviour: modular arithmetic for WRAP, clamping for SAT/ONESHOT.
  task automatic model_clock();
    bit tk;
    int s, m, md, t;
    bit clamp;
    tk = en;
`ifdef COUNTER_PRESCALER_EN
    tk = en && (m_pre == P - 1);
    if (ld) m_pre = 0;
    else if (en) m_pre = (m_pre == P - 1) ? 0 : m_pre + 1;
`endif
    md = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
    for (int i = 0; i < 3; i++) begin
      s = cur_step(i);
      m = mx[i];
      m_tc[i] = 0;
      if (ld) begin
        t = cur_lv(i);
        m_cnt[i]  = (t > m) ? m : t;
        m_halt[i] = 0;
      end else if (tk && m_halt[i] == 0 && s != 0) begin
        clamp = 0;
        if (!dir) begin
          t = m_cnt[i] + s;
          if (t <= m) m_cnt[i] = t;
          else if (md == 0) begin
            m_cnt[i] = t % (m + 1);
            m_tc[i]  = 1;
          end else begin
            m_tc[i]  = (m_cnt[i] != m) ? 1 : 0;
            m_cnt[i] = m;
            clamp    = 1;
          end
        end else begin
          if (s <= m_cnt[i]) m_cnt[i] = m_cnt[i] - s;
          else if (md == 0) begin
            m_cnt[i] = (m_cnt[i] - s + m + 1) % (m + 1);
            m_tc[i]  = 1;
          end else begin
            m_tc[i]  = (m_cnt[i] != 0) ? 1 : 0;
            m_cnt[i] = 0;
            clamp    = 1;
          end
        end
        if (clamp && md == 2) m_halt[i] = 1;
      end
    end
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic one_tick();
    en = 1'b1;
    repeat (PSC) cycle();
  endtask

  initial begin
    int exp032[4] = '{3, 6, 9, 2};
    int exp033[3] = '{2, 0, 0};
    int exp034[5] = '{100, 200, 255, 255, 255};

    rst = 1'b1; en = 1'b0; ld = 1'b0; dir = 1'b0; mode = 2'd0;
    lv_a = '0; lv_b = '0; lv_c = '0;
    step_a = 8'd3; step_b = 8'd1; step_c = 9'd1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // WRAP up by 3 against MAX_VAL=9
    for (int k = 0; k < 4; k++) begin
      one_tick();
      chk("wrap_up_count", 32'(count_a), exp032[k]);
      chk("wrap_up_tc",    32'(tc_a),    (k == 3) ? 1 : 0);
    end
    en = 1'b0;

    // SAT down by 4 after loading 6
    mode = 2'd1; dir = 1'b1; step_a = 8'd4; lv_a = 8'd6; ld = 1'b1;
    cycle();
    ld = 1'b0;
    chk("sat_load", 32'(count_a), 6);
    for (int k = 0; k < 3; k++) begin
      one_tick();
      chk("sat_down_count", 32'(count_a), exp033[k]);
      chk("sat_down_tc",    32'(tc_a),    (k == 1) ? 1 : 0);
    end
    en = 1'b0;

    // ONESHOT up by 100 against MAX_VAL=255, then reload
    do_reset();
    mode = 2'd2; dir = 1'b0; step_b = 8'd100;
    for (int k = 0; k < 5; k++) begin
      one_tick();
      chk("oneshot_count", 32'(count_b), exp034[k]);
      chk("oneshot_tc",    32'(tc_b),    (k == 2) ? 1 : 0);
      chk("oneshot_done",  32'(done_b),  (k >= 2) ? 1 : 0);
    end
    en = 1'b0;
    lv_b = 8'd7; ld = 1'b1;
    cycle();
    ld = 1'b0;
    chk("oneshot_reload_count", 32'(count_b), 7);
    chk("oneshot_reload_done",  32'(done_b),  0);

    // load beats tick, load value clamped to MAX_VAL=200
    mode = 2'd0; en = 1'b1; ld = 1'b1; lv_c = 9'd300;
    cycle();
    chk("load_clamp_count", 32'(count_c), 200);
    chk("load_clamp_tc",    32'(tc_c),    0);
    ld = 1'b0; en = 1'b0;

`ifdef COUNTER_PRESCALER_EN
    // reset in the middle of a prescale period
    do_reset();
    step_a = 8'd1; dir = 1'b0; mode = 2'd0; en = 1'b1;
    repeat (P + 2) cycle();
    chk("presc_before_rst", 32'(count_a), 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("presc_async_rst", 32'(count_a), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= P; k++) begin
      cycle();
      chk("presc_after_rst", 32'(count_a), (k == P) ? 1 : 0);
    end
    en = 1'b0;
`endif

    // randomized traffic with occasional async reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99, 0) == 0) begin
        do_reset();
      end else begin
        en = ($urandom_range(9, 0) < 7);
        ld = ($urandom_range(24, 0) == 0);
        if ($urandom_range(7, 0) == 0) dir  = 1'($urandom);
        if ($urandom_range(7, 0) == 0) mode = 2'($urandom_range(3, 0));
        step_a = 8'($urandom_range(9, 0));
        step_b = 8'($urandom_range(255, 0));
        step_c = 9'($urandom_range(200, 0));
        lv_a = 8'($urandom);
        lv_b = 8'($urandom);
        lv_c = 9'($urandom);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
